// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants for the SHA-256 message padder: block geometry, padding marker and FSM encodings.
package sha256_msg_padder_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned BLOCK_W     = WORD_W * BLOCK_WORDS;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned LEN_W       = 64;
    localparam int unsigned LEN_IDX     = 14;
    localparam int unsigned BCNT_W      = 3;

    localparam logic [IDX_W-1:0]  IDX_LEN  = IDX_W'(LEN_IDX);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    // FSM encodings
    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_PAD    = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

endpackage

// File: rtl/sha256_msg_padder.sv
// Streams 32-bit big-endian message words into 512-bit SHA-256 blocks with
// the 0x80 marker, zero fill and 64-bit bit length already applied.
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
(
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iValid,
    output logic                oReady,
    input  logic [WORD_W-1:0]   iData,
    input  logic                iLast,
    input  logic [BCNT_W-1:0]   iByteCnt,
    output logic [BLOCK_W-1:0]  oBlock,
    output logic                oBlockValid,
    input  logic                iBlockReady,
    output logic                oFirst,
    output logic                oLast
);

    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_buf [BLOCK_WORDS];
    logic [IDX_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len;
    logic              r_pad_pending;
    logic              r_first;
    logic              r_last;
    logic              r_more;      // padding continues in the next block
    logic              r_ready;
    logic              r_block_valid;

    logic [1:0]        w_state_nxt;
    logic              w_accept;
    logic [BCNT_W-1:0] w_nbytes;
    logic              w_wr_en;
    logic              w_wr_len;
    logic              w_clear;
    logic [WORD_W-1:0] w_wr_data;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic              w_pend_nxt;
    logic              w_first_nxt;
    logic              w_last_nxt;
    logic              w_more_nxt;

    // Keep the first n bytes of the final word, drop the marker right after them.
    function automatic logic [WORD_W-1:0] f_mask_last(input logic [WORD_W-1:0] d,
                                                      input logic [BCNT_W-1:0] n);
        case (n)
            3'd0:    return PAD_WORD;
            3'd1:    return {d[31:24], 8'h80, 16'h0000};
            3'd2:    return {d[31:16], 8'h80, 8'h00};
            3'd3:    return {d[31:8], 8'h80};
            default: return d;
        endcase
    endfunction

    assign w_accept = iValid & r_ready;
    assign w_nbytes = (iByteCnt > 3'd4) ? 3'd4 : iByteCnt;

    assign oReady      = r_ready;
    assign oBlockValid = r_block_valid;
    assign oFirst      = r_first;
    assign oLast       = r_last;

    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_blk
        assign oBlock[BLOCK_W-1-WORD_W*g -: WORD_W] = r_buf[g];
    end

    // Next-state and datapath control decisions
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_len    = 1'b0;
        w_clear     = 1'b0;
        w_wr_data   = '0;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_pend_nxt  = r_pad_pending;
        w_first_nxt = r_first;
        w_last_nxt  = r_last;
        w_more_nxt  = r_more;
        case (r_state)
            ST_ACCEPT: begin
                if (w_accept) begin
                    w_wr_en   = 1'b1;
                    w_idx_nxt = IDX_W'(r_idx + 4'd1);
                    if (!iLast) begin
                        w_wr_data = iData;
                        w_len_nxt = r_len + LEN_W'(32);
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_EMIT;
                            w_last_nxt  = 1'b0;
                            w_more_nxt  = 1'b0;
                        end
                    end else begin
                        w_wr_data  = f_mask_last(iData, w_nbytes);
                        w_pend_nxt = (w_nbytes == 3'd4);
                        w_len_nxt  = r_len + LEN_W'({w_nbytes, 3'b000});
                        w_last_nxt = 1'b0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_EMIT;
                            w_more_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                w_wr_en = 1'b1;
                if (r_pad_pending) begin
                    w_wr_data  = PAD_WORD;
                    w_pend_nxt = 1'b0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_EMIT;
                        w_last_nxt  = 1'b0;
                        w_more_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = IDX_W'(r_idx + 4'd1);
                    end
                end else if (r_idx < IDX_LEN) begin
                    w_idx_nxt = IDX_W'(r_idx + 4'd1);
                end else if (r_idx == IDX_LEN) begin
                    w_wr_len    = 1'b1;
                    w_state_nxt = ST_EMIT;
                    w_last_nxt  = 1'b1;
                    w_more_nxt  = 1'b0;
                end else begin
                    // no room for the length field: close this block with zeros
                    w_state_nxt = ST_EMIT;
                    w_last_nxt  = 1'b0;
                    w_more_nxt  = 1'b1;
                end
            end
            ST_EMIT: begin
                if (r_block_valid && iBlockReady) begin
                    w_clear    = 1'b1;
                    w_idx_nxt  = '0;
                    w_last_nxt = 1'b0;
                    w_more_nxt = 1'b0;
                    if (r_last) begin
                        w_first_nxt = 1'b1;
                        w_len_nxt   = '0;
                        w_state_nxt = ST_ACCEPT;
                    end else begin
                        w_first_nxt = 1'b0;
                        w_state_nxt = r_more ? ST_PAD : ST_ACCEPT;
                    end
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // State register
    always_ff @(posedge iClk) begin
        if (iReset) r_state <= ST_ACCEPT;
        else        r_state <= w_state_nxt;
    end

    // Control registers and registered handshake outputs
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_idx         <= '0;
            r_len         <= '0;
            r_pad_pending <= 1'b0;
            r_first       <= 1'b1;
            r_last        <= 1'b0;
            r_more        <= 1'b0;
            r_ready       <= 1'b0;
            r_block_valid <= 1'b0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_len         <= w_len_nxt;
            r_pad_pending <= w_pend_nxt;
            r_first       <= w_first_nxt;
            r_last        <= w_last_nxt;
            r_more        <= w_more_nxt;
            r_ready       <= (w_state_nxt == ST_ACCEPT);
            r_block_valid <= (w_state_nxt == ST_EMIT);
        end
    end

    // Block buffer: cleared after each transfer, one word or the length pair per cycle
    always_ff @(posedge iClk) begin
        if (iReset || w_clear) begin
            for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
        end else if (w_wr_len) begin
            r_buf[LEN_IDX]     <= r_len[63:32];
            r_buf[LEN_IDX + 1] <= r_len[31:0];
        end else if (w_wr_en) begin
            r_buf[r_idx] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized self-checking bench for sha256_msg_padder against a byte-level padding model.
module tb_sha256_msg_padder;

    localparam int unsigned BW = 512;

    logic           iClk = 1'b0;
    logic           iReset;
    logic           iValid;
    logic           oReady;
    logic [31:0]    iData;
    logic           iLast;
    logic [2:0]     iByteCnt;
    logic [511:0]   oBlock;
    logic           oBlockValid;
    logic           iBlockReady;
    logic           oFirst;
    logic           oLast;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t         expq[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           rdy_mode = 0;
    int           acc_cyc = 0;
    int           rise_cyc = 0;
    logic [511:0] last_blk = '0;
    logic [511:0] held = '0;
    logic         hold = 1'b0;
    logic         prev_valid = 1'b0;

    sha256_msg_padder dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iValid      (iValid),
        .oReady      (oReady),
        .iData       (iData),
        .iLast       (iLast),
        .iByteCnt    (iByteCnt),
        .oBlock      (oBlock),
        .oBlockValid (oBlockValid),
        .iBlockReady (iBlockReady),
        .oFirst      (oFirst),
        .oLast       (oLast)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: byte-level FIPS 180-4 padding of the whole message, cut into 64-byte blocks
    task automatic model_push(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        exp_t         e;
        int           nb;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = p[64*b + k];
            e.blk   = blk;
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            expq.push_back(e);
        end
    endtask

    // Block-ready driver
    initial begin
        iBlockReady = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            case (rdy_mode)
                0:       iBlockReady = 1'b1;
                1:       iBlockReady = 1'($urandom);
                default: iBlockReady = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard on transfer, stability while stalled
    always @(negedge iClk) begin
        if (iReset) begin
            prev_valid <= 1'b0;
            hold       <= 1'b0;
        end else begin
            if (oBlockValid) begin
                check("ready_low_in_emit", BW'(oReady), BW'(1'b0));
                if (hold) check("block_stable", oBlock, held);
                if (!prev_valid) rise_cyc <= cyc;
                if (iBlockReady) begin
                    check("block_expected", BW'(expq.size() != 0), BW'(1'b1));
                    if (expq.size() != 0) begin
                        check("block_data", oBlock, expq[0].blk);
                        check("block_first", BW'(oFirst), BW'(expq[0].first));
                        check("block_last", BW'(oLast), BW'(expq[0].last));
                        void'(expq.pop_front());
                    end
                    last_blk <= oBlock;
                end
                hold <= !iBlockReady;
                held <= oBlock;
            end else begin
                hold <= 1'b0;
            end
            prev_valid <= oBlockValid;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] n);
        int t;
        repeat ($urandom_range(0, 2)) begin
            @(posedge iClk);
            #1;
        end
        iValid   = 1'b1;
        iData    = d;
        iLast    = l;
        iByteCnt = n;
        t = 0;
        forever begin
            @(negedge iClk);
            if (oReady) begin
                iValid = 1'b1;
                break;
            end
            iValid = 1'($urandom);
            t++;
            if (t > 3000) begin
                check("accept_timeout", BW'(oReady), BW'(1'b1));
                iValid = 1'b0;
                return;
            end
        end
        @(posedge iClk);
        #1;
        acc_cyc  = cyc;
        iValid   = 1'b0;
        iData    = $urandom;
        iLast    = 1'($urandom);
        iByteCnt = 3'($urandom);
    endtask

    // Send a message; non-final words count 4 bytes, the final word min(n,4)
    task automatic send_msg(input logic [31:0] words[$], input logic [2:0] n, input bit push);
        logic [7:0] bytes[$];
        int         nb;
        for (int w = 0; w < words.size(); w++) begin
            nb = (w == words.size() - 1) ? ((n > 3'd4) ? 4 : int'(n)) : 4;
            for (int k = 0; k < nb; k++) bytes.push_back(words[w][31-8*k -: 8]);
        end
        if (push) model_push(bytes);
        for (int w = 0; w < words.size(); w++)
            send_word(words[w], (w == words.size() - 1), (w == words.size() - 1) ? n : 3'($urandom));
    endtask

    task automatic rand_words(input int nw, output logic [31:0] words[$]);
        words = {};
        for (int i = 0; i < nw; i++) words.push_back($urandom);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || oBlockValid) && t < 5000) begin
            @(posedge iClk);
            #1;
            t++;
        end
        check("drain", BW'(expq.size()), BW'(0));
    endtask

    task automatic do_reset();
        iValid = 1'b0;
        iReset = 1'b1;
        repeat (2) begin
            @(posedge iClk);
            #1;
        end
        @(negedge iClk);
        check("rst_ready", BW'(oReady), BW'(1'b0));
        check("rst_valid", BW'(oBlockValid), BW'(1'b0));
        check("rst_first", BW'(oFirst), BW'(1'b1));
        check("rst_last", BW'(oLast), BW'(1'b0));
        check("rst_block", oBlock, BW'(0));
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        check("ready_after_reset", BW'(oReady), BW'(1'b1));
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!oBlockValid && t < 200) begin
            @(negedge iClk);
            t++;
        end
        check("emit_reached", BW'(oBlockValid), BW'(1'b1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[$];
        iReset   = 1'b1;
        iValid   = 1'b0;
        iData    = '0;
        iLast    = 1'b0;
        iByteCnt = '0;
        rdy_mode = 0;
        do_reset();

        // empty message
        words = {32'hdead_beef};
        send_msg(words, 3'd0, 1'b1);
        wait_drain();
        check("empty_w0", BW'(last_blk[511:480]), BW'(32'h8000_0000));
        check("empty_rest", BW'(last_blk[479:0]), BW'(0));

        // "abc" with garbage in the unused low byte
        words = {32'h6162_63ff};
        send_msg(words, 3'd3, 1'b1);
        wait_drain();
        check("abc_w0", BW'(last_blk[511:480]), BW'(32'h6162_6380));
        check("abc_w15", BW'(last_blk[31:0]), BW'(32'h0000_0018));
        check("abc_latency", BW'(rise_cyc - acc_cyc), BW'(14));

        // 56 bytes: marker spills into word 14, length in a second block
        rand_words(14, words);
        send_msg(words, 3'd4, 1'b1);
        wait_drain();
        check("b56_w15", BW'(last_blk[31:0]), BW'(32'h0000_01c0));
        check("b56_w0", BW'(last_blk[511:480]), BW'(0));

        // 64 bytes: full data block, then marker+length block
        rand_words(16, words);
        send_msg(words, 3'd4, 1'b1);
        wait_drain();
        check("b64_w0", BW'(last_blk[511:480]), BW'(32'h8000_0000));
        check("b64_w15", BW'(last_blk[31:0]), BW'(32'h0000_0200));

        // backpressure: hold the first block 20 cycles while more words wait
        rdy_mode = 2;
        rand_words(20, words);
        fork
            send_msg(words, 3'($urandom), 1'b1);
            begin
                wait_valid();
                repeat (20) @(posedge iClk);
                #1;
                rdy_mode = 1;
            end
        join
        wait_drain();
        rdy_mode = 0;

        // reset after 7 words, then a clean "abc"
        rand_words(7, words);
        for (int i = 0; i < 7; i++) send_word(words[i], 1'b0, 3'd0);
        do_reset();
        words = {32'h6162_6300};
        send_msg(words, 3'd3, 1'b1);
        wait_drain();
        check("abc_after_rst_w0", BW'(last_blk[511:480]), BW'(32'h6162_6380));

        // reset while a block is stalled in EMIT
        rdy_mode = 2;
        rand_words(16, words);
        send_msg(words, 3'd0, 1'b0);
        wait_valid();
        repeat (3) @(posedge iClk);
        #1;
        do_reset();
        rdy_mode = 0;

        // randomized back-to-back messages
        for (int m = 0; m < 30; m++) begin
            rdy_mode = int'($urandom_range(0, 1));
            rand_words(int'($urandom_range(1, 40)), words);
            send_msg(words, 3'($urandom), 1'b1);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
